// File: rtl/iic_pkg.sv
// Shared definitions for the IIC slave controller.
// Contents: slave FSM state enum, ACK/NACK and R/W bit encodings, default slave address.
package iic_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StWaitStop
    } iic_slv_state_e;

    localparam logic IIC_ACK      = 1'b0;
    localparam logic IIC_NACK     = 1'b1;
    localparam logic IIC_RW_WRITE = 1'b0;
    localparam logic IIC_RW_READ  = 1'b1;

    localparam logic [6:0] IIC_SLV_ADDR_DEFAULT = 7'h50;

endpackage

// File: rtl/iic_slv_line_sync.sv
// IIC line conditioner: synchronizes raw SCL/SDA, optionally filters them, and
// produces single-cycle bus events.
// Optional feature macro: IIC_SLV_GLITCH_FILT_EN (3-sample stability filter, +2 clk latency).
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   scl_i, sda_i  raw pad inputs
//   sda_o         conditioned SDA level, aligned with the event outputs
//   scl_rise_o    SCL 0->1
//   scl_fall_o    SCL 1->0
//   start_o       SDA 1->0 while SCL high
//   stop_o        SDA 0->1 while SCL high
module iic_slv_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_ln;
    logic                   sda_ln;

    // Reset to the idle bus level so leaving reset never looks like an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef IIC_SLV_GLITCH_FILT_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;
    logic       scl_filt;
    logic       sda_filt;

    // Output follows the input only once the current and two previous samples agree.
    always_comb begin
        scl_filt = scl_filt_q;
        sda_filt = sda_filt_q;
        if (scl_s == scl_hist_q[0] && scl_s == scl_hist_q[1]) begin
            scl_filt = scl_s;
        end
        if (sda_s == sda_hist_q[0] && sda_s == sda_hist_q[1]) begin
            sda_filt = sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_hist_q <= {sda_hist_q[0], sda_s};
            scl_filt_q <= scl_filt;
            sda_filt_q <= sda_filt;
        end
    end

    assign scl_ln = scl_filt;
    assign sda_ln = sda_filt;
`else
    assign scl_ln = scl_s;
    assign sda_ln = sda_s;
`endif

    logic scl_prev_q;
    logic sda_prev_q;
    logic scl_rise_q;
    logic scl_fall_q;
    logic start_q;
    logic stop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_prev_q <= scl_ln;
            sda_prev_q <= sda_ln;
            scl_rise_q <= scl_ln & ~scl_prev_q;
            scl_fall_q <= ~scl_ln & scl_prev_q;
            start_q    <= scl_ln & scl_prev_q & sda_prev_q & ~sda_ln;
            stop_q     <= scl_ln & scl_prev_q & ~sda_prev_q & sda_ln;
        end
    end

    // sda_prev_q holds the level that produced the current event outputs.
    assign sda_o      = sda_prev_q;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/iic_slv_ctrl.sv
// Byte-level IIC slave controller with an 8-bit auto-incrementing register pointer.
// Optional feature macro: IIC_SLV_GLITCH_FILT_EN (passed through to iic_slv_line_sync).
// Ports:
//   clk, rst        system clock (>= 16x SCL), synchronous active-high reset
//   scl_i, sda_i    raw bus lines
//   sda_oe          1 = pull SDA low (open drain)
//   slv_reg_addr    register pointer, valid with slv_wr / slv_rd_req
//   slv_wdata       write data, valid with slv_wr
//   slv_wr          1-clk write strobe
//   slv_rd_req      1-clk read request; slv_rdata captured 2 clk later
//   slv_rdata       read data from the application
//   slv_busy        addressed (address ACKed) until START/STOP
//   slv_trans_done  1-clk pulse on STOP ending an addressed transfer
//   slv_trans_err   sticky START/STOP mid-byte flag, cleared by the next START
module iic_slv_ctrl
    import iic_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = IIC_SLV_ADDR_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] slv_reg_addr,
    output logic [7:0] slv_wdata,
    output logic       slv_wr,
    output logic       slv_rd_req,
    input  logic [7:0] slv_rdata,
    output logic       slv_busy,
    output logic       slv_trans_done,
    output logic       slv_trans_err
);

    logic sda_ln;
    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    iic_slv_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_o     (sda_ln),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_ev),
        .stop_o    (stop_ev)
    );

    iic_slv_state_e state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       bit_open_q, bit_open_d;
    logic       oe_q, oe_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       rd_pipe_q;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] rx_byte;
    logic       last_bit;
    logic       addr_match;
    logic       bit_fall;
    logic       in_data;
    logic       err_cond;

    assign rx_byte    = {shreg_q[6:0], sda_ln};
    assign last_bit   = (bit_cnt_q == 3'd7);
    assign addr_match = (rx_byte[7:1] == SLV_ADDR);
    // bit_cnt counts completed bits (a rise followed by a fall). The SCL fall that
    // follows START closes no bit, and the rise preceding Sr/STOP opens one that
    // never completes, so neither disturbs the count.
    assign bit_fall   = scl_fall & bit_open_q;
    assign in_data    = (state_q == StAddr) || (state_q == StReg) ||
                        (state_q == StWdata) || (state_q == StRdata);
    assign err_cond   = busy_q & in_data & (bit_cnt_q != 3'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus conditions override bit activity.
    always_comb begin
        state_d = state_q;
        if (start_ev) begin
            state_d = StAddr;
        end else if (stop_ev) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StAddr: begin
                    if (scl_rise && last_bit) begin
                        state_d = addr_match ? StAddrAck : StWaitStop;
                    end
                end
                StAddrAck: begin
                    if (bit_fall && bit_cnt_q != 3'd0) begin
                        state_d = (rw_q == IIC_RW_WRITE) ? StReg : StRdata;
                    end
                end
                StReg: begin
                    if (scl_rise && last_bit) state_d = StRegAck;
                end
                StRegAck: begin
                    if (bit_fall && bit_cnt_q != 3'd0) state_d = StWdata;
                end
                StWdata: begin
                    if (scl_rise && last_bit) state_d = StWdataAck;
                end
                StWdataAck: begin
                    if (bit_fall && bit_cnt_q != 3'd0) state_d = StWdata;
                end
                StRdata: begin
                    if (scl_rise && last_bit) state_d = StRdataAck;
                end
                StRdataAck: begin
                    if (scl_rise && bit_cnt_q != 3'd0 && sda_ln == IIC_NACK) begin
                        state_d = StWaitStop;
                    end else if (bit_fall && bit_cnt_q != 3'd0) begin
                        state_d = StRdata;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next-state logic
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        bit_open_d = bit_open_q;
        oe_d       = oe_q;
        ptr_d      = ptr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (wr_q) ptr_d = ptr_q + 8'd1;
        if (rd_pipe_q) shreg_d = slv_rdata;

        if (scl_rise) begin
            bit_open_d = 1'b1;
        end else if (scl_fall) begin
            bit_open_d = 1'b0;
        end

        if (start_ev) begin
            bit_cnt_d  = 3'd0;
            bit_open_d = 1'b0;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            err_d      = err_cond;
        end else if (stop_ev) begin
            oe_d   = 1'b0;
            busy_d = 1'b0;
            done_d = busy_q;
            err_d  = err_q | err_cond;
        end else begin
            unique case (state_q)
                StAddr, StReg, StWdata: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte;
                        if (last_bit) begin
                            bit_cnt_d = 3'd0;
                            if (state_q == StAddr && addr_match) begin
                                busy_d = 1'b1;
                                rw_d   = rx_byte[0];
                            end
                            if (state_q == StReg) ptr_d = rx_byte;
                            if (state_q == StWdata) begin
                                wr_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                        end
                    end else if (bit_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // Ack phases: first fall drives ACK, second fall ends the ACK bit.
                StAddrAck, StRegAck, StWdataAck: begin
                    if (bit_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            oe_d      = 1'b1;
                            bit_cnt_d = 3'd1;
                        end else begin
                            bit_cnt_d = 3'd0;
                            oe_d      = 1'b0;
                            if (state_q == StAddrAck && rw_q == IIC_RW_READ) begin
                                oe_d = ~shreg_q[7];
                            end
                        end
                    end else if (scl_rise && state_q == StAddrAck && bit_cnt_q != 3'd0 &&
                                 rw_q == IIC_RW_READ) begin
                        rd_d = 1'b1;
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        if (last_bit) bit_cnt_d = 3'd0;
                    end else if (bit_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        oe_d      = ~shreg_q[7];
                    end
                end
                StRdataAck: begin
                    if (bit_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 3'd1;
                        end else begin
                            bit_cnt_d = 3'd0;
                            oe_d      = ~shreg_q[7];
                        end
                    end else if (scl_rise && bit_cnt_q != 3'd0 && sda_ln == IIC_ACK) begin
                        // Pointer and request register together, so the request
                        // carries the incremented pointer.
                        ptr_d = ptr_q + 8'd1;
                        rd_d  = 1'b1;
                    end
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            bit_open_q <= 1'b0;
            oe_q       <= 1'b0;
            ptr_q      <= 8'h00;
            wdata_q    <= 8'h00;
            rw_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rd_pipe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_open_q <= bit_open_d;
            oe_q       <= oe_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rd_pipe_q  <= rd_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign sda_oe         = oe_q;
    assign slv_reg_addr   = ptr_q;
    assign slv_wdata      = wdata_q;
    assign slv_wr         = wr_q;
    assign slv_rd_req     = rd_q;
    assign slv_busy       = busy_q;
    assign slv_trans_done = done_q;
    assign slv_trans_err  = err_q;

endmodule

// File: tb/tb_iic_slv_ctrl.sv
// Self-checking bench for iic_slv_ctrl: a bit-banged IIC master plus an
// application register-file model.
module tb_iic_slv_ctrl;

    localparam int Q = 8;  // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] slv_reg_addr;
    logic [7:0] slv_wdata;
    logic       slv_wr;
    logic       slv_rd_req;
    logic [7:0] slv_rdata = 8'h00;
    logic       slv_busy;
    logic       slv_trans_done;
    logic       slv_trans_err;

    // Open-drain bus with pull-up
    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    iic_slv_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .scl_i         (scl_i),
        .sda_i         (sda_i),
        .sda_oe        (sda_oe),
        .slv_reg_addr  (slv_reg_addr),
        .slv_wdata     (slv_wdata),
        .slv_wr        (slv_wr),
        .slv_rd_req    (slv_rd_req),
        .slv_rdata     (slv_rdata),
        .slv_busy      (slv_busy),
        .slv_trans_done(slv_trans_done),
        .slv_trans_err (slv_trans_err)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic [7:0] rd_a[$];
    int done_cnt = 0;
    int oe_cnt   = 0;
    int busy_cnt = 0;

    function automatic logic [7:0] app_data(input logic [7:0] a);
        case (a)
            8'h20:   app_data = 8'h3C;
            8'h21:   app_data = 8'hC3;
            default: app_data = a ^ 8'hA5;
        endcase
    endfunction

    // Application side: log strobes, answer read requests.
    always @(negedge clk) begin
        if (slv_wr) begin
            wr_a.push_back(slv_reg_addr);
            wr_d.push_back(slv_wdata);
        end
        if (slv_rd_req) begin
            rd_a.push_back(slv_reg_addr);
            slv_rdata = app_data(slv_reg_addr);
        end
        if (slv_trans_done) done_cnt++;
        if (sda_oe) oe_cnt++;
        if (slv_busy) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        s = sda_i;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            d = {d[6:0], s};
        end
        send_bit(ack_in, s);
    endtask

    function automatic logic [7:0] qget(input logic [7:0] q[$], input int idx);
        if (idx < q.size()) qget = q[idx];
        else qget = 8'hXX;
    endfunction

    typedef struct {
        logic [7:0] reg_addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] exp_a0;
        logic [7:0] exp_a1;
    } wr_vec_t;

    wr_vec_t vecs[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         w0, r0, d0, o0, b0;

        vecs[0] = '{reg_addr: 8'h10, d0: 8'h55, d1: 8'hAA, exp_a0: 8'h10, exp_a1: 8'h11};
        vecs[1] = '{reg_addr: 8'hFF, d0: 8'h12, d1: 8'h34, exp_a0: 8'hFF, exp_a1: 8'h00};
        vecs[2] = '{reg_addr: 8'h7F, d0: 8'h00, d1: 8'hFF, exp_a0: 8'h7F, exp_a1: 8'h80};

        tick(5);
        check("reset_outputs", {sda_oe, slv_reg_addr, slv_wdata, slv_wr, slv_rd_req,
                                slv_busy, slv_trans_done, slv_trans_err}, 32'h0);
        rst = 1'b0;
        tick(Q);

        // Register writes
        for (int i = 0; i < 3; i++) begin
            w0 = wr_a.size();
            d0 = done_cnt;
            bus_start();
            write_byte(8'hA0, ack);
            check($sformatf("v%0d_addr_ack", i), ack, 1'b0);
            write_byte(vecs[i].reg_addr, ack);
            check($sformatf("v%0d_reg_ack", i), ack, 1'b0);
            write_byte(vecs[i].d0, ack);
            check($sformatf("v%0d_d0_ack", i), ack, 1'b0);
            write_byte(vecs[i].d1, ack);
            check($sformatf("v%0d_d1_ack", i), ack, 1'b0);
            bus_stop();
            tick(4);
            check($sformatf("v%0d_wr_count", i), wr_a.size() - w0, 2);
            check($sformatf("v%0d_wr_addr0", i), qget(wr_a, w0), vecs[i].exp_a0);
            check($sformatf("v%0d_wr_data0", i), qget(wr_d, w0), vecs[i].d0);
            check($sformatf("v%0d_wr_addr1", i), qget(wr_a, w0 + 1), vecs[i].exp_a1);
            check($sformatf("v%0d_wr_data1", i), qget(wr_d, w0 + 1), vecs[i].d1);
            check($sformatf("v%0d_done", i), done_cnt - d0, 1);
            check($sformatf("v%0d_busy_after", i), slv_busy, 1'b0);
            check($sformatf("v%0d_err", i), slv_trans_err, 1'b0);
        end

        // Random read with repeated START
        w0 = wr_a.size();
        r0 = rd_a.size();
        d0 = done_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("rd_addrw_ack", ack, 1'b0);
        write_byte(8'h20, ack);
        check("rd_reg_ack", ack, 1'b0);
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addrr_ack", ack, 1'b0);
        read_byte(1'b0, rb);
        check("rd_byte0", rb, 8'h3C);
        read_byte(1'b1, rb);
        check("rd_byte1", rb, 8'hC3);
        bus_stop();
        tick(4);
        check("rd_req_count", rd_a.size() - r0, 2);
        check("rd_req_addr0", qget(rd_a, r0), 8'h20);
        check("rd_req_addr1", qget(rd_a, r0 + 1), 8'h21);
        check("rd_no_wr", wr_a.size() - w0, 0);
        check("rd_done", done_cnt - d0, 1);
        check("rd_err", slv_trans_err, 1'b0);

        // Address mismatch
        w0 = wr_a.size();
        r0 = rd_a.size();
        d0 = done_cnt;
        o0 = oe_cnt;
        b0 = busy_cnt;
        bus_start();
        write_byte(8'h90, ack);
        check("mis_nack", ack, 1'b1);
        write_byte(8'h55, ack);
        check("mis_nack2", ack, 1'b1);
        bus_stop();
        tick(4);
        check("mis_oe", oe_cnt - o0, 0);
        check("mis_busy", busy_cnt - b0, 0);
        check("mis_strobes", (wr_a.size() - w0) + (rd_a.size() - r0), 0);
        check("mis_done", done_cnt - d0, 0);

        // Abort: STOP after 4 data bits
        w0 = wr_a.size();
        bus_start();
        write_byte(8'hA0, ack);
        check("abt_addr_ack", ack, 1'b0);
        write_byte(8'h10, ack);
        check("abt_reg_ack", ack, 1'b0);
        send_bit(1'b1, ack);
        send_bit(1'b0, ack);
        send_bit(1'b1, ack);
        send_bit(1'b0, ack);
        bus_stop();
        tick(4);
        check("abt_err", slv_trans_err, 1'b1);
        check("abt_no_wr", wr_a.size() - w0, 0);
        check("abt_busy", slv_busy, 1'b0);
        check("abt_oe", sda_oe, 1'b0);
        bus_start();
        check("abt_err_cleared", slv_trans_err, 1'b0);
        bus_stop();
        tick(4);
        check("abt_err_stays_clear", slv_trans_err, 1'b0);

        // Reset while the slave drives a 0 data bit
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h20, ack);
        bus_start();
        write_byte(8'hA1, ack);
        check("rst_pre_ack", ack, 1'b0);
        check("rst_pre_oe", sda_oe, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_all_outputs", {sda_oe, slv_reg_addr, slv_wdata, slv_wr, slv_rd_req,
                                  slv_busy, slv_trans_done, slv_trans_err}, 32'h0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(Q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
